// File: rtl/odd_even_sort_unit_pkg.sv
// Shared definitions for the odd-even transposition sorter: default width,
// FSM encodings and the phase-counter width helper.
package odd_even_sort_unit_pkg;

    localparam int DEF_BIT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SORT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Wide enough to hold a phase count of num_elem itself.
    function automatic int phase_cnt_w(input int num_elem);
        return $clog2(num_elem + 1);
    endfunction

endpackage

// File: rtl/odd_even_sort_unit_compare_exchange.sv
// One compare-exchange cell: lo is the value for the left slot, hi for the right.
// Equal inputs are never swapped, which keeps the sort stable.
module compare_exchange
    import odd_even_sort_unit_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 descend,
    output logic [BIT_WIDTH-1:0] lo,
    output logic [BIT_WIDTH-1:0] hi,
    output logic                 swapped
);

    assign swapped = descend ? (a < b) : (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/odd_even_sort_unit.sv
// Odd-even transposition sorter with early exit, ready/valid/ack handshake
// and direct median output.
//
// state | meaning
// IDLE  | ready for start_i, last result held on out_data_o
// SORT  | one compare-exchange phase per cycle
// DONE  | valid_o high, result held until ack_i
module odd_even_sort_unit
    import odd_even_sort_unit_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH,
    parameter int NUM_ELEM  = 9
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic                              start_i,
    input  logic                              descend_i,
    input  logic [NUM_ELEM*BIT_WIDTH-1:0]     in_data_i,
    output logic                              ready_o,
    output logic                              valid_o,
    input  logic                              ack_i,
    output logic [NUM_ELEM*BIT_WIDTH-1:0]     out_data_o,
    output logic [BIT_WIDTH-1:0]              median_o,
    output logic [phase_cnt_w(NUM_ELEM)-1:0]  phases_o
);

    localparam int PW = phase_cnt_w(NUM_ELEM);
    localparam int DW = NUM_ELEM * BIT_WIDTH;

    logic [1:0]           state;
    logic [DW-1:0]        data_q;
    logic                 desc_q;
    logic [PW-1:0]        phase_cnt;
    logic [PW-1:0]        phases_q;
    logic                 prev_swap;

    logic [BIT_WIDTH-1:0] cur    [NUM_ELEM];
    logic [BIT_WIDTH-1:0] ev_nxt [NUM_ELEM];
    logic [BIT_WIDTH-1:0] od_nxt [NUM_ELEM];
    logic [NUM_ELEM-1:0]  ev_sw;
    logic [NUM_ELEM-1:0]  od_sw;
    logic [DW-1:0]        phase_data;
    logic                 any_swap;
    logic                 sort_exit;

    // Even network pairs (0,1),(2,3)..; odd network pairs (1,2),(3,4)..
    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_elem
        assign cur[k] = data_q[k*BIT_WIDTH +: BIT_WIDTH];

        if ((k % 2 == 0) && (k + 1 < NUM_ELEM)) begin : g_ev_pair
            compare_exchange #(.BIT_WIDTH(BIT_WIDTH)) u_cx (
                .a       (cur[k]),
                .b       (cur[k+1]),
                .descend (desc_q),
                .lo      (ev_nxt[k]),
                .hi      (ev_nxt[k+1]),
                .swapped (ev_sw[k])
            );
        end else if (k % 2 == 0) begin : g_ev_edge
            assign ev_nxt[k] = cur[k];
            assign ev_sw[k]  = 1'b0;
        end else begin : g_ev_right
            assign ev_sw[k]  = 1'b0;
        end

        if ((k % 2 == 1) && (k + 1 < NUM_ELEM)) begin : g_od_pair
            compare_exchange #(.BIT_WIDTH(BIT_WIDTH)) u_cx (
                .a       (cur[k]),
                .b       (cur[k+1]),
                .descend (desc_q),
                .lo      (od_nxt[k]),
                .hi      (od_nxt[k+1]),
                .swapped (od_sw[k])
            );
        end else if ((k == 0) || (k % 2 == 1)) begin : g_od_edge
            assign od_nxt[k] = cur[k];
            assign od_sw[k]  = 1'b0;
        end else begin : g_od_right
            assign od_sw[k]  = 1'b0;
        end
    end

    always_comb begin
        phase_data = '0;
        any_swap   = phase_cnt[0] ? (|od_sw) : (|ev_sw);
        for (int k = 0; k < NUM_ELEM; k++) begin
            phase_data[k*BIT_WIDTH +: BIT_WIDTH] = phase_cnt[0] ? od_nxt[k] : ev_nxt[k];
        end
    end

    // Two consecutive swap-free phases prove the data is sorted.
    assign sort_exit = (phase_cnt == PW'(NUM_ELEM - 1)) ||
                       ((phase_cnt != '0) && !any_swap && !prev_swap);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            desc_q    <= 1'b0;
            phase_cnt <= '0;
            phases_q  <= '0;
            prev_swap <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        data_q    <= in_data_i;
                        desc_q    <= descend_i;
                        phase_cnt <= '0;
                        prev_swap <= 1'b0;
                        state     <= ST_SORT;
                    end
                end
                ST_SORT: begin
                    data_q    <= phase_data;
                    prev_swap <= any_swap;
                    phase_cnt <= phase_cnt + 1'b1;
                    if (sort_exit) begin
                        phases_q <= phase_cnt + 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ack_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ready_o    = (state == ST_IDLE);
    assign valid_o    = (state == ST_DONE);
    assign out_data_o = data_q;
    assign median_o   = data_q[(NUM_ELEM/2)*BIT_WIDTH +: BIT_WIDTH];
    assign phases_o   = phases_q;

endmodule

// File: tb/tb_odd_even_sort_unit.sv
// Directed bench for odd_even_sort_unit: a 9x8 instance with hand-computed
// vectors plus 2/4/16-element 12-bit instances checked against a queue sort.
module tb_odd_even_sort_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        desc = 1'b0;
    logic        ack = 1'b0;
    logic [71:0] din = '0;
    logic        ready;
    logic        valid;
    logic [71:0] dout;
    logic [7:0]  median;
    logic [3:0]  phases;

    int n_cmp = 0;
    int n_bad = 0;
    bit sweep_go = 1'b0;
    bit sweep_done [3];

    always #5 CLK = ~CLK;

    odd_even_sort_unit #(.BIT_WIDTH(8), .NUM_ELEM(9)) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .start_i    (start),
        .descend_i  (desc),
        .in_data_i  (din),
        .ready_o    (ready),
        .valid_o    (valid),
        .ack_i      (ack),
        .out_data_o (dout),
        .median_o   (median),
        .phases_o   (phases)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] pack9(input int v [9]);
        logic [71:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[k*8 +: 8] = 8'(v[k]);
        return r;
    endfunction

    // Start at a negedge, release at the next; lat counts edges after the start edge.
    task automatic run9(input logic [71:0] vec, input logic d, output int lat);
        @(negedge CLK);
        din = vec; desc = d; start = 1'b1;
        @(negedge CLK);
        start = 1'b0; desc = ~d; din = ~vec;
        lat = 0;
        while (!valid && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        if (!valid) chk("timeout9", 0, 1);
    endtask

    task automatic ack9(input string tag);
        @(negedge CLK);
        ack = 1'b1;
        @(negedge CLK);
        ack = 1'b0;
        chk({tag, "_ack_valid"}, valid, 0);
        chk({tag, "_ack_ready"}, ready, 1);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_sweep
        localparam int N  = (g == 0) ? 2 : (g == 1) ? 4 : 16;
        localparam int BW = 12;
        localparam int PW = $clog2(N + 1);

        logic            s_start = 1'b0;
        logic            s_desc = 1'b0;
        logic            s_ack = 1'b0;
        logic [N*BW-1:0] s_din = '0;
        logic            s_ready;
        logic            s_valid;
        logic [N*BW-1:0] s_dout;
        logic [BW-1:0]   s_med;
        logic [PW-1:0]   s_ph;

        odd_even_sort_unit #(.BIT_WIDTH(BW), .NUM_ELEM(N)) u_dut (
            .CLK        (CLK),
            .RST        (RST),
            .start_i    (s_start),
            .descend_i  (s_desc),
            .in_data_i  (s_din),
            .ready_o    (s_ready),
            .valid_o    (s_valid),
            .ack_i      (s_ack),
            .out_data_o (s_dout),
            .median_o   (s_med),
            .phases_o   (s_ph)
        );

        initial begin
            int vals[$];
            logic [N*BW-1:0] exp;
            int lat;
            logic d;
            wait (sweep_go);
            for (int v = 0; v < 6; v++) begin
                vals.delete();
                for (int i = 0; i < N; i++)
                    vals.push_back(v == 0 ? i * 5 : int'($urandom_range(0, v == 1 ? 3 : 4095)));
                d = (v % 2 == 1);
                @(negedge CLK);
                for (int i = 0; i < N; i++) s_din[i*BW +: BW] = BW'(vals[i]);
                s_desc = d; s_start = 1'b1;
                @(negedge CLK);
                s_start = 1'b0; s_desc = ~d;
                lat = 0;
                while (!s_valid && lat < 100) begin
                    @(negedge CLK);
                    lat++;
                end
                if (!s_valid) chk($sformatf("sw%0d_timeout", N), 0, 1);
                if (d) vals.rsort(); else vals.sort();
                for (int i = 0; i < N; i++) exp[i*BW +: BW] = BW'(vals[i]);
                chk($sformatf("sw%0d_v%0d_data", N, v), s_dout, exp);
                chk($sformatf("sw%0d_v%0d_median", N, v), s_med, vals[N/2]);
                chk($sformatf("sw%0d_v%0d_lat_le_n", N, v), lat <= N, 1);
                chk($sformatf("sw%0d_v%0d_phases", N, v), s_ph, lat);
                if (v == 0) chk($sformatf("sw%0d_sorted_lat", N), lat, 2);
                @(negedge CLK);
                s_ack = 1'b1;
                @(negedge CLK);
                s_ack = 1'b0;
            end
            sweep_done[g] = 1'b1;
        end
    end

    initial begin
        int rev [9]  = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        int asc [9]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        int dup [9]  = '{3, 7, 3, 0, 255, 7, 1, 1, 3};
        int dsrt [9] = '{255, 7, 7, 3, 3, 3, 1, 1, 0};
        int alt [9]  = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
        int lat;
        int t;
        bit seen;

        repeat (3) @(negedge CLK);
        chk("rst_ready", ready, 1);
        chk("rst_valid", valid, 0);
        chk("rst_data", dout, 0);
        chk("rst_median", median, 0);
        chk("rst_phases", phases, 0);
        RST = 1'b0;

        sweep_go = 1'b1;
        t = 0;
        while (!(sweep_done[0] && sweep_done[1] && sweep_done[2]) && t < 20000) begin
            @(negedge CLK);
            t++;
        end
        chk("sweep_timeout", t < 20000, 1);

        run9(pack9(rev), 1'b0, lat);
        chk("rev_data", dout, pack9(asc));
        chk("rev_median", median, 5);
        chk("rev_lat", lat, 9);
        chk("rev_phases", phases, 9);
        chk("rev_busy", ready, 0);
        ack9("rev");

        run9(pack9(asc), 1'b0, lat);
        chk("srt_data", dout, pack9(asc));
        chk("srt_lat", lat, 2);
        chk("srt_phases", phases, 2);
        chk("srt_median", median, 5);
        ack9("srt");

        run9(pack9(dup), 1'b1, lat);
        chk("dsc_data", dout, pack9(dsrt));
        chk("dsc_median", median, 3);
        chk("dsc_lat_le9", lat <= 9, 1);
        chk("dsc_phases", phases, lat);

        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            start = (c == 1);
            din = pack9(alt);
            chk($sformatf("hold%0d_valid", c), valid, 1);
            chk($sformatf("hold%0d_data", c), dout, pack9(dsrt));
            chk($sformatf("hold%0d_ready", c), ready, 0);
        end
        @(negedge CLK);
        start = 1'b0;
        ack = 1'b1;
        @(negedge CLK);
        chk("ack_valid", valid, 0);
        chk("ack_ready", ready, 1);
        chk("idle_keeps_data", dout, pack9(dsrt));
        ack = 1'b0; din = pack9(rev); desc = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        chk("b2b_accept", ready, 0);
        lat = 0;
        while (!valid && lat < 50) begin
            @(negedge CLK);
            lat++;
        end
        chk("b2b_lat", lat, 9);
        chk("b2b_data", dout, pack9(asc));
        ack9("b2b");

        @(negedge CLK);
        din = pack9(rev); desc = 1'b0; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_data", dout, 0);
        chk("mid_rst_phases", phases, 0);
        RST = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (valid) seen = 1'b1;
        end
        chk("mid_rst_no_valid", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
